// File: rtl/deser_align_ctrl_if.sv
// Bundles the alignment controller's bring-up inputs, training-lane data and SERDES/IDELAY controls.
// Latency: none; the interface is only wiring.
// Backpressure: none; every signal is a level or a single-cycle pulse in the RxClkDiv domain.
interface deser_align_ctrl_if #(
    parameter int W = 4
);
    logic          i_mmcm_alignd;
    logic          i_idly_rdy;
    logic          i_retrain;
    logic [W-1:0]  i_srds_data;
    logic          o_bitslip;
    logic          o_idly_ce;
    logic          o_idly_inc;
    logic [4:0]    o_idly_tap_cnt;
    logic          o_aligned;
    logic          o_align_err;

    // Controller side.
    modport slave (
        input  i_mmcm_alignd, i_idly_rdy, i_retrain, i_srds_data,
        output o_bitslip, o_idly_ce, o_idly_inc, o_idly_tap_cnt, o_aligned, o_align_err
    );

    // Environment side: clocking infrastructure and ISERDES/IDELAY model.
    modport master (
        output i_mmcm_alignd, i_idly_rdy, i_retrain, i_srds_data,
        input  o_bitslip, o_idly_ce, o_idly_inc, o_idly_tap_cnt, o_aligned, o_align_err
    );
endinterface

// File: rtl/deser_align_ctrl.sv
// Brings up an LVDS deserializer: waits for MMCM/IDELAYCTRL, then word-aligns using BITSLIP and IDELAY taps.
// Latency: training word registered once (1 cycle); lock after settle + check + repeated matches.
// Backpressure: none; Bitslip/IdlyCe are single-cycle pulses, spaced by the settle/slip-wait states.
module deser_align_ctrl #(
    parameter int                           C_IoSrdsDataWidth = 4,
    parameter logic [C_IoSrdsDataWidth-1:0] C_ClockPattern    = 4'b1010,
    parameter int                           C_SettleCycles    = 16,
    parameter int                           C_SlipWait        = 3,
    parameter int                           C_MatchCount      = 8,
    parameter int                           C_MaxTaps         = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    deser_align_ctrl_if.slave    if_bus
);

    // One shared wait counter serves both SETTLE and SLIPWAIT, so it is sized for the longer one.
    localparam int C_WaitMax = (C_SettleCycles > C_SlipWait) ? C_SettleCycles : C_SlipWait;
    localparam int C_WaitW   = $clog2(C_WaitMax + 1);
    localparam int C_SlipW   = $clog2(C_IoSrdsDataWidth + 1);
    localparam int C_TapsW   = $clog2(C_MaxTaps + 1);
    localparam int C_MatchW  = $clog2(C_MatchCount + 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_SLIPWAIT,
        ST_VERIFY,
        ST_TAP,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          r_mmcm_s1, r_mmcm_s2;
    logic                          r_idly_s1, r_idly_s2;
    logic [C_IoSrdsDataWidth-1:0]  r_word;
    logic [C_WaitW-1:0]            r_wait,      w_wait_nxt;
    logic [C_SlipW-1:0]            r_slip_cnt,  w_slip_nxt;
    logic [C_TapsW-1:0]            r_taps,      w_taps_nxt;
    logic [C_MatchW-1:0]           r_match_cnt, w_match_nxt;
    logic [4:0]                    r_tap_cnt,   w_tap_nxt;
    logic                          w_bitslip;
    logic                          w_idly_ce;
    logic                          w_link_up;
    logic                          w_match;

    assign w_link_up = r_mmcm_s2 & r_idly_s2;
    assign w_match   = (r_word == C_ClockPattern);

    // Two-flop synchronisers for the asynchronous MMCM and IDELAYCTRL status inputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mmcm_s1 <= 1'b0;
            r_mmcm_s2 <= 1'b0;
            r_idly_s1 <= 1'b0;
            r_idly_s2 <= 1'b0;
        end else begin
            r_mmcm_s1 <= if_bus.i_mmcm_alignd;
            r_mmcm_s2 <= r_mmcm_s1;
            r_idly_s1 <= if_bus.i_idly_rdy;
            r_idly_s2 <= r_idly_s1;
        end
    end

    // State register plus counters; the training word is registered here and compared a cycle later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_word      <= '0;
            r_wait      <= '0;
            r_slip_cnt  <= '0;
            r_taps      <= '0;
            r_match_cnt <= '0;
            r_tap_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_word      <= if_bus.i_srds_data;
            r_wait      <= w_wait_nxt;
            r_slip_cnt  <= w_slip_nxt;
            r_taps      <= w_taps_nxt;
            r_match_cnt <= w_match_nxt;
            r_tap_cnt   <= w_tap_nxt;
        end
    end

    // Next-state and pulse decode; link loss and Retrain override whatever the state wanted.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_slip_nxt  = r_slip_cnt;
        w_taps_nxt  = r_taps;
        w_match_nxt = r_match_cnt;
        w_tap_nxt   = r_tap_cnt;
        w_bitslip   = 1'b0;
        w_idly_ce   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_wait_nxt  = '0;
                w_slip_nxt  = '0;
                w_taps_nxt  = '0;
                w_match_nxt = '0;
                if (w_link_up) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_wait == C_WaitW'(C_SettleCycles - 1)) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_wait_nxt  = r_wait + C_WaitW'(1);
                end
            end
            ST_CHECK: begin
                if (w_match) begin
                    w_match_nxt = C_MatchW'(1);
                    w_state_nxt = ST_VERIFY;
                end else if (r_slip_cnt < C_SlipW'(C_IoSrdsDataWidth - 1)) begin
                    w_state_nxt = ST_SLIP;
                end else begin
                    w_state_nxt = ST_TAP;
                end
            end
            ST_SLIP: begin
                w_bitslip   = 1'b1;
                w_slip_nxt  = r_slip_cnt + C_SlipW'(1);
                w_wait_nxt  = '0;
                w_state_nxt = ST_SLIPWAIT;
            end
            ST_SLIPWAIT: begin
                if (r_wait == C_WaitW'(C_SlipWait - 1)) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_wait_nxt  = r_wait + C_WaitW'(1);
                end
            end
            ST_VERIFY: begin
                // A mismatch restarts the search from CHECK; slipping waits for CHECK to decide.
                if (!w_match) begin
                    w_match_nxt = '0;
                    w_state_nxt = ST_CHECK;
                end else if (r_match_cnt == C_MatchW'(C_MatchCount)) begin
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_match_nxt = r_match_cnt + C_MatchW'(1);
                end
            end
            ST_TAP: begin
                if (r_taps == C_TapsW'(C_MaxTaps - 1)) begin
                    w_state_nxt = ST_FAIL;
                end else begin
                    w_idly_ce   = 1'b1;
                    w_tap_nxt   = r_tap_cnt + 5'd1;
                    w_taps_nxt  = r_taps + C_TapsW'(1);
                    w_slip_nxt  = '0;
                    w_wait_nxt  = '0;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_LOCKED: begin
                // Data lanes share the SERDES clocking, so stray mismatches do not break lock.
                w_state_nxt = ST_LOCKED;
            end
            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if ((r_state != ST_IDLE) && !w_link_up) begin
            w_state_nxt = ST_IDLE;
        end
        if (if_bus.i_retrain) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Pulses decode straight from state so an async reset drops them at once.
    assign if_bus.o_bitslip      = w_bitslip;
    assign if_bus.o_idly_ce      = w_idly_ce;
    assign if_bus.o_idly_inc     = 1'b1;
    assign if_bus.o_idly_tap_cnt = r_tap_cnt;
    assign if_bus.o_aligned      = (r_state == ST_LOCKED);
    assign if_bus.o_align_err    = (r_state == ST_FAIL);

endmodule

// File: tb/tb_deser_align_ctrl.sv
// Directed bench for deser_align_ctrl with a small ISERDES/IDELAY model driving the training lane.
// Latency: expectations are hand-derived cycle counts from reset release.
// Backpressure: not applicable; the bench tracks pulse counts and spacing.
module tb_deser_align_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    deser_align_ctrl_if #(.W(W)) bus ();

    deser_align_ctrl dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .if_bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus controls (written only by the initial block).
    int   mode      = 0;   // 0 const pattern, 1 slip model, 2 match on tap 5, 3 never match
    int   rot_start = 0;   // slips needed before the word boundary is right
    logic glitch    = 1'b0;

    // Monitor state (written only by the monitor process).
    int   cyc        = 0;
    int   n_slip     = 0;
    int   n_ce       = 0;
    int   n_bad      = 0;
    int   min_gap    = 1000;
    int   model_tap  = 0;
    int   rot_off    = 0;
    int   last_slip  = -1000;
    logic prev_pulse = 1'b0;

    logic [W-1:0] w_word;

    // Training-lane model: the word depends on the slip offset or the modelled IDELAY tap.
    always_comb begin
        w_word = 4'b0000;
        case (mode)
            0: w_word = 4'b1010;
            1: w_word = (rot_off == 0) ? 4'b1010 : (((rot_off % 2) == 1) ? 4'b0101 : 4'b0110);
            2: w_word = (model_tap == 5) ? 4'b1010 : 4'b0000;
            default: w_word = 4'b0000;
        endcase
        if (glitch) w_word = 4'b0000;
    end
    assign bus.i_srds_data = w_word;

    // Cycle counter: number of rising edges since reset was released.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Pulse monitor: counts pulses, tracks slip spacing, advances the slip and tap models.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            model_tap  <= 0;
            rot_off    <= rot_start;
            last_slip  <= -1000;
            prev_pulse <= 1'b0;
        end else begin
            if (bus.o_bitslip) begin
                n_slip    <= n_slip + 1;
                if (cyc - last_slip < min_gap) min_gap <= cyc - last_slip;
                last_slip <= cyc;
                rot_off   <= (rot_off + 3) % 4;
            end
            if (bus.o_idly_ce) begin
                n_ce      <= n_ce + 1;
                model_tap <= (model_tap + 1) % 32;
            end
            if ((bus.o_bitslip && bus.o_idly_ce) || ((bus.o_bitslip || bus.o_idly_ce) && prev_pulse))
                n_bad <= n_bad + 1;
            prev_pulse <= bus.o_bitslip | bus.o_idly_ce;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Waits at negedges for Aligned (sel 0) or AlignErr (sel 1), bounded by budget cycles.
    task automatic wait_flag(input int sel, input int budget, input string tag, output int at);
        int n;
        n = 0;
        while ((((sel == 0) ? bus.o_aligned : bus.o_align_err) !== 1'b1) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
        check(tag, 32'((sel == 0) ? bus.o_aligned : bus.o_align_err), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int t;
        int s0, c0, s1, c1;
        bus.i_mmcm_alignd = 1'b1;
        bus.i_idly_rdy    = 1'b1;
        bus.i_retrain     = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_bitslip", 32'(bus.o_bitslip), 32'd0);
        check("rst_idly_ce", 32'(bus.o_idly_ce), 32'd0);
        check("rst_idly_inc", 32'(bus.o_idly_inc), 32'd1);
        check("rst_tap_cnt", 32'(bus.o_idly_tap_cnt), 32'd0);
        check("rst_aligned", 32'(bus.o_aligned), 32'd0);
        check("rst_align_err", 32'(bus.o_align_err), 32'd0);

        // 1: already aligned word, lock after sync + settle + check + verify.
        s0 = n_slip; c0 = n_ce;
        rst = 1'b0;
        wait_flag(0, 200, "t1_aligned", t);
        check("t1_lock_cycle_28_to_30", 32'(t >= 28 && t <= 30), 32'd1);
        check("t1_bitslips", 32'(n_slip - s0), 32'd0);
        check("t1_idly_ce", 32'(n_ce - c0), 32'd0);

        // 2: boundary two slips away.
        mode = 1; rot_start = 2;
        s0 = n_slip; c0 = n_ce;
        do_reset();
        wait_flag(0, 300, "t2_aligned", t);
        check("t2_bitslips", 32'(n_slip - s0), 32'd2);
        check("t2_idly_ce", 32'(n_ce - c0), 32'd0);
        check("t2_tap_cnt", 32'(bus.o_idly_tap_cnt), 32'd0);
        check("t2_min_slip_gap_ge_4", 32'(min_gap >= 4), 32'd1);

        // 3: only tap 5 gives the pattern; three slips tried on each failing tap.
        mode = 2;
        s0 = n_slip; c0 = n_ce;
        do_reset();
        wait_flag(0, 1000, "t3_aligned", t);
        check("t3_bitslips", 32'(n_slip - s0), 32'd15);
        check("t3_idly_ce", 32'(n_ce - c0), 32'd5);
        check("t3_tap_cnt", 32'(bus.o_idly_tap_cnt), 32'd5);

        // 4: never matches; exhaust taps, fail, then retrain.
        mode = 3;
        s0 = n_slip; c0 = n_ce;
        do_reset();
        wait_flag(1, 3000, "t4_align_err", t);
        check("t4_aligned", 32'(bus.o_aligned), 32'd0);
        check("t4_idly_ce", 32'(n_ce - c0), 32'd31);
        check("t4_bitslips", 32'(n_slip - s0), 32'd96);
        check("t4_tap_cnt", 32'(bus.o_idly_tap_cnt), 32'd31);
        s1 = n_slip; c1 = n_ce;
        repeat (50) @(negedge clk);
        check("t4_no_pulses_in_fail", 32'((n_slip - s1) + (n_ce - c1)), 32'd0);
        check("t4_err_sticky", 32'(bus.o_align_err), 32'd1);
        mode = 0;
        bus.i_retrain = 1'b1;
        @(negedge clk);
        bus.i_retrain = 1'b0;
        check("t4_err_cleared", 32'(bus.o_align_err), 32'd0);
        check("t4_tap_kept", 32'(bus.o_idly_tap_cnt), 32'd31);
        c1 = n_ce;
        wait_flag(0, 200, "t4_realigned", t);
        check("t4_tap_after_realign", 32'(bus.o_idly_tap_cnt), 32'd31);
        check("t4_no_ce_on_realign", 32'(n_ce - c1), 32'd0);

        // 5: MMCM loss while locked, then restore.
        bus.i_mmcm_alignd = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_aligned_drop_3cyc", 32'(bus.o_aligned), 32'd0);
        repeat (100) @(negedge clk);
        check("t5_aligned_while_down", 32'(bus.o_aligned), 32'd0);
        bus.i_mmcm_alignd = 1'b1;
        wait_flag(0, 200, "t5_realigned", t);

        // 6: one bad word while verify holds five matches; lock moves out to cycle 34.
        mode = 0;
        s0 = n_slip;
        do_reset();
        repeat (23) @(negedge clk);
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        check("t6_not_locked_at_glitch", 32'(bus.o_aligned), 32'd0);
        wait_flag(0, 200, "t6_aligned", t);
        check("t6_lock_cycle_33_to_36", 32'(t >= 33 && t <= 36), 32'd1);
        check("t6_no_bitslip", 32'(n_slip - s0), 32'd0);

        // 7: async reset while a Bitslip pulse is high.
        mode = 1; rot_start = 2;
        do_reset();
        t = 0;
        while (bus.o_bitslip !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t7_bitslip_seen", 32'(bus.o_bitslip), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t7_bitslip_dropped", 32'(bus.o_bitslip), 32'd0);
        check("t7_idly_ce_low", 32'(bus.o_idly_ce), 32'd0);
        @(negedge clk);

        // Whole-run pulse rules.
        check("pulse_overlap_or_back_to_back", 32'(n_bad), 32'd0);
        check("min_slip_gap_ge_4", 32'(min_gap >= 4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
